// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//
// Initiator side of a single-cycle, word-only data memory. The core hands over
// one byte/half/word load or store per valid/ready handshake. The LSU drives a
// word address, write data and a write strobe into the memory and samples the
// memory's combinational read data. Sub-word stores are done as
// read-modify-write: read the word, replace one lane, write the word back.
//
// Handshake: a request transfers on the rising clk edge where
// req_valid && req_ready. req_ready is high only in IDLE, so at most one
// request is in flight. The response is a single-cycle rsp_valid pulse with
// no backpressure. rsp_rdata and rsp_error are meaningful only while
// rsp_valid is high.
//
// Optional feature macro: ALIGN_CHECK_EN
//   defined   : a misaligned half (addr[0]=1) or word (addr[1:0]!=0) faults.
//               There is no memory access, rsp_error=1, rsp_rdata=0, and the
//               response comes one cycle after accept.
//   undefined : no faults. The low address bits are ignored, so the access is
//               rounded down to the containing half/word. rsp_error is tied 0.
//
// Ports
//   clk, reset          clock (rising edge); asynchronous active-low reset
//   req_valid/ready     request handshake
//   req_write           1 = store, 0 = load
//   req_size            00 byte, 01 half, 10/11 word
//   req_signed          sign-extend sub-word loads
//   req_addr            byte address
//   req_wdata           right-aligned store data
//   rsp_valid           one-cycle completion pulse
//   rsp_rdata           load result (0 for stores and faults)
//   rsp_error           misalignment fault
//   Data_Address        word address to memory ({addr[31:2],2'b00}), 0 when idle
//   Write_Data          word to memory
//   Write_Enable        memory write strobe, committed at rising clk
//   Data_RD             memory read data, combinational from Data_Address
//   dbg_state           current FSM state (0 IDLE, 1 READ, 2 WRITE, 3 RESP)
// -----------------------------------------------------------------------------
module load_store_unit #(
  parameter int data_width = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [data_width-1:0] req_addr,
  input  logic [data_width-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [data_width-1:0] rsp_rdata,
  output logic                  rsp_error,
  output logic [data_width-1:0] Data_Address,
  output logic [data_width-1:0] Write_Data,
  output logic                  Write_Enable,
  input  logic [data_width-1:0] Data_RD,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t state, state_next;

  // Request fields latched at the handshake edge.
  logic                  write_q;
  logic [1:0]            size_q;
  logic                  signed_q;
  logic [data_width-1:0] addr_q;
  logic [data_width-1:0] wdata_q;

  // Word captured in READ. A sub-word store merges its new lane into it.
  logic [data_width-1:0] rd_word_q;
  logic [data_width-1:0] rdata_q;

  logic                  accept;
  logic                  req_is_word;
  logic                  fault;
  logic [data_width-1:0] byte_shift;
  logic [data_width-1:0] half_shift;
  logic [data_width-1:0] load_result;
  logic [data_width-1:0] merged_word;

  assign accept      = req_valid && (state == IDLE);
  // Size 11 is treated as a word access.
  assign req_is_word = req_size[1];

`ifdef ALIGN_CHECK_EN
  logic error_q;

  always_comb begin
    fault = 1'b0;
    if (req_size == 2'b01) begin
      fault = req_addr[0];
    end else if (req_is_word) begin
      fault = (req_addr[1:0] != 2'b00);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      error_q <= 1'b0;
    end else if (accept) begin
      error_q <= fault;
    end
  end

  assign rsp_error = error_q;
`else
  assign fault     = 1'b0;
  assign rsp_error = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (fault) begin
            state_next = RESP;
          end else if (req_write && req_is_word) begin
            // A whole-word store needs no read-back.
            state_next = WRITE;
          end else begin
            // Loads, and sub-word stores that must read the word first.
            state_next = READ;
          end
        end
      end
      READ:    state_next = write_q ? WRITE : RESP;
      WRITE:   state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Latched request and result registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      write_q   <= 1'b0;
      size_q    <= 2'b00;
      signed_q  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rd_word_q <= '0;
      rdata_q   <= '0;
    end else begin
      if (accept) begin
        write_q  <= req_write;
        size_q   <= req_size;
        signed_q <= req_signed;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        // Stores and faults respond with zero data.
        rdata_q  <= '0;
      end
      if (state == READ) begin
        rd_word_q <= Data_RD;
        if (!write_q) begin
          rdata_q <= load_result;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Lane extraction for loads (little-endian lanes)
  // ---------------------------------------------------------------------------
  assign byte_shift = Data_RD >> {addr_q[1:0], 3'b000};
  assign half_shift = Data_RD >> {addr_q[1], 4'b0000};

  always_comb begin
    load_result = Data_RD;
    case (size_q)
      2'b00: begin
        if (signed_q) begin
          load_result = {{(data_width-8){byte_shift[7]}}, byte_shift[7:0]};
        end else begin
          load_result = {{(data_width-8){1'b0}}, byte_shift[7:0]};
        end
      end
      2'b01: begin
        if (signed_q) begin
          load_result = {{(data_width-16){half_shift[15]}}, half_shift[15:0]};
        end else begin
          load_result = {{(data_width-16){1'b0}}, half_shift[15:0]};
        end
      end
      default: load_result = Data_RD;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Lane merge for sub-word stores
  // ---------------------------------------------------------------------------
  always_comb begin
    merged_word = rd_word_q;
    case (size_q)
      2'b00:   merged_word[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      2'b01:   merged_word[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: merged_word = wdata_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Memory-side outputs are decoded from state. Because they are not separate
  // registers, an asynchronous reset in WRITE drops Write_Enable immediately
  // and the store is never committed.
  // ---------------------------------------------------------------------------
  always_comb begin
    Data_Address = '0;
    Write_Data   = '0;
    Write_Enable = 1'b0;
    case (state)
      READ: begin
        Data_Address = {addr_q[data_width-1:2], 2'b00};
      end
      WRITE: begin
        Data_Address = {addr_q[data_width-1:2], 2'b00};
        Write_Data   = merged_word;
        Write_Enable = 1'b1;
      end
      default: begin
        Data_Address = '0;
      end
    endcase
  end

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign rsp_rdata = rdata_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
//
// Directed bench for load_store_unit against a four-word data memory. The
// memory aliases by Data_Address[3:2]. Its initial words are
// 0x0=5, 0x4=3, 0x8=7 and 0xC=0.
//
// Every response entry in exp_q packs three fields:
//   {due cycle (posedge count seen at the negedge where rsp_valid must be
//    high), rsp_error, rsp_rdata}
// so a single comparison covers latency, error flag and data.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

  localparam int DW = 32;
  localparam int W  = 32 + 1 + DW;

  logic          clk;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [1:0]    req_size;
  logic          req_signed;
  logic [DW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_error;
  logic [DW-1:0] Data_Address;
  logic [DW-1:0] Write_Data;
  logic          Write_Enable;
  logic [DW-1:0] Data_RD;
  logic [1:0]    dbg_state;

  logic [DW-1:0] mem [4];

  logic [W-1:0]  exp_q[$];
  int            compared;
  int            mismatched;
  int            cyc;
  int            we_cnt;
  logic [DW-1:0] we_addr;
  logic [DW-1:0] rd_addr;

  load_store_unit #(.data_width(DW)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_signed   (req_signed),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_error    (rsp_error),
    .Data_Address (Data_Address),
    .Write_Data   (Write_Data),
    .Write_Enable (Write_Enable),
    .Data_RD      (Data_RD),
    .dbg_state    (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Clock, cycle counter, memory
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    mem[0] = 32'd5;
    mem[1] = 32'd3;
    mem[2] = 32'd7;
    mem[3] = 32'd0;
  end

  always @(posedge clk) begin
    if (Write_Enable) mem[Data_Address[3:2]] <= Write_Data;
  end

  assign Data_RD = mem[Data_Address[3:2]];

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard
  // ---------------------------------------------------------------------------
  initial begin
    we_cnt  = 0;
    we_addr = '0;
    rd_addr = '0;
  end

  always @(negedge clk) begin
    logic [W-1:0] e;
    logic [W-1:0] got;
    if (Write_Enable) begin
      we_cnt  = we_cnt + 1;
      we_addr = Data_Address;
    end
    if (dbg_state == 2'd1) rd_addr = Data_Address;
    if (rsp_valid) begin
      compared = compared + 1;
      got = {32'(cyc), rsp_error, rsp_rdata};
      if (exp_q.size() == 0) begin
        mismatched = mismatched + 1;
        $display("FAIL unexpected_rsp: got cycle=%0d err=%0b rdata=%h, no response expected",
                 cyc, rsp_error, rsp_rdata);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          mismatched = mismatched + 1;
          $display("FAIL rsp: got cycle=%0d err=%0b rdata=%h, expected cycle=%0d err=%0b rdata=%h",
                   got[W-1 -: 32], got[DW], got[DW-1:0], e[W-1 -: 32], e[DW], e[DW-1:0]);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver and check tasks
  // ---------------------------------------------------------------------------
  task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    compared = compared + 1;
    if (got !== exp) begin
      mismatched = mismatched + 1;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Issue one request. If push is set, also queue the expected response.
  task automatic issue(input logic wr, input logic [1:0] sz, input logic sg,
                       input logic [DW-1:0] a, input logic [DW-1:0] wd,
                       input logic [DW-1:0] exp_rd, input logic exp_err,
                       input int lat, input bit push);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      chk("req_ready_timeout", {31'd0, req_ready}, 32'd1);
      return;
    end
    req_valid  = 1'b1;
    req_write  = wr;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    if (push) exp_q.push_back({32'(cyc + lat - 1), exp_err, exp_rd});
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      chk("drain_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
    chk({tag, "_rsp_error"}, {31'd0, rsp_error}, 32'd0);
    chk({tag, "_addr"}, Data_Address, 32'd0);
    chk({tag, "_wdata"}, Write_Data, 32'd0);
    chk({tag, "_we"}, {31'd0, Write_Enable}, 32'd0);
    chk({tag, "_state"}, {30'd0, dbg_state}, 32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int n;
    int we_base;
    compared   = 0;
    mismatched = 0;
    reset      = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_size   = 2'b00;
    req_signed = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;

    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    reset = 1'b1;

    // 1: word load 0x4
    we_base = we_cnt;
    issue(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 32'h00000003, 1'b0, 2, 1'b1);
    drain();
    chk("t1_read_addr", rd_addr, 32'h4);
    chk("t1_no_write", 32'(we_cnt - we_base), 32'd0);

    // 2: word store then load back
    we_base = we_cnt;
    issue(1'b1, 2'b10, 1'b0, 32'h8, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1'b1);
    drain();
    chk("t2_we_pulses", 32'(we_cnt - we_base), 32'd1);
    chk("t2_we_addr", we_addr, 32'h8);
    issue(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 32'hDEADBEEF, 1'b0, 2, 1'b1);
    drain();

    // 3: byte store 0xAB to 0xD, then signed and unsigned byte loads
    we_base = we_cnt;
    issue(1'b1, 2'b00, 1'b0, 32'hD, 32'h123456AB, 32'h0, 1'b0, 3, 1'b1);
    drain();
    chk("t3_we_pulses", 32'(we_cnt - we_base), 32'd1);
    chk("t3_we_addr", we_addr, 32'hC);
    chk("t3_mem_word", mem[3], 32'h0000AB00);
    issue(1'b0, 2'b00, 1'b1, 32'hD, 32'h0, 32'hFFFFFFAB, 1'b0, 2, 1'b1);
    issue(1'b0, 2'b00, 1'b0, 32'hD, 32'h0, 32'h000000AB, 1'b0, 2, 1'b1);
    drain();

    // 4: half store 0x8001 to 0xE, half load signed, word load of 0xC
    issue(1'b1, 2'b01, 1'b0, 32'hE, 32'hFFFF8001, 32'h0, 1'b0, 3, 1'b1);
    issue(1'b0, 2'b01, 1'b1, 32'hE, 32'h0, 32'hFFFF8001, 1'b0, 2, 1'b1);
    issue(1'b0, 2'b10, 1'b0, 32'hC, 32'h0, 32'h8001AB00, 1'b0, 2, 1'b1);
    drain();
    chk("t4_mem_word", mem[3], 32'h8001AB00);

    // Extra lanes: lower half of 0xDEADBEEF, top byte, size 11 as word
    issue(1'b0, 2'b01, 1'b0, 32'h8, 32'h0, 32'h0000BEEF, 1'b0, 2, 1'b1);
    issue(1'b0, 2'b01, 1'b1, 32'h8, 32'h0, 32'hFFFFBEEF, 1'b0, 2, 1'b1);
    issue(1'b0, 2'b00, 1'b1, 32'hB, 32'h0, 32'hFFFFFFDE, 1'b0, 2, 1'b1);
    issue(1'b0, 2'b00, 1'b0, 32'h4, 32'h0, 32'h00000003, 1'b0, 2, 1'b1);
    issue(1'b0, 2'b11, 1'b1, 32'h0, 32'h0, 32'h00000005, 1'b0, 2, 1'b1);
    drain();

    // 5: sub-word store aborted by reset while in WRITE
    issue(1'b1, 2'b00, 1'b0, 32'h1, 32'h00000011, 32'h0, 1'b0, 3, 1'b0);
    n = 0;
    while (dbg_state != 2'd2 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("t5_reached_write", {30'd0, dbg_state}, 32'd2);
    chk("t5_we_before", {31'd0, Write_Enable}, 32'd1);
    reset = 1'b0;
    #1;
    chk_reset_outputs("t5_abort");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("t5_mem_unchanged", mem[0], 32'h00000005);

    // 6: misaligned word load at 0x6, and a misaligned half load at 0x5
    we_base = we_cnt;
`ifdef ALIGN_CHECK_EN
    issue(1'b0, 2'b10, 1'b0, 32'h6, 32'h0, 32'h0, 1'b1, 1, 1'b1);
    issue(1'b0, 2'b01, 1'b0, 32'h5, 32'h0, 32'h0, 1'b1, 1, 1'b1);
    issue(1'b1, 2'b10, 1'b0, 32'h2, 32'hCAFEF00D, 32'h0, 1'b1, 1, 1'b1);
    drain();
    chk("t6_no_write", 32'(we_cnt - we_base), 32'd0);
    chk("t6_mem_kept", mem[0], 32'h00000005);
`else
    issue(1'b0, 2'b10, 1'b0, 32'h6, 32'h0, 32'h00000003, 1'b0, 2, 1'b1);
    drain();
    chk("t6_read_addr", rd_addr, 32'h4);
    issue(1'b0, 2'b01, 1'b0, 32'h5, 32'h0, 32'h00000003, 1'b0, 2, 1'b1);
    drain();
    chk("t6_no_write", 32'(we_cnt - we_base), 32'd0);
`endif

    repeat (4) @(negedge clk);
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
